// File: rtl/vm_pkg.sv
// Shared definitions for the coin vending controller: coin values, credit
// state encoding and the total-to-(pr, re, next credit) decision function.
package vm_pkg;

  localparam int COIN1  = 1;
  localparam int COIN2  = 2;
  localparam int CALC_W = 8;

  typedef logic [CALC_W-1:0] calc_t;

  // Credit states for the default PRICE=3 build; wider prices extend the count
  typedef logic [1:0] state_t;
  localparam state_t S0 = 2'd0;
  localparam state_t S1 = 2'd1;
  localparam state_t S2 = 2'd2;

  typedef struct packed {
    logic  pr;
    logic  re;
    calc_t next;
  } vend_t;

  // One vend consumes price units; one unit of any excess goes back as change
  function automatic vend_t vend_calc(input calc_t total, input calc_t price);
    vend_t r;
    calc_t excess;
    r.pr   = 1'b0;
    r.re   = 1'b0;
    r.next = total;
    excess = '0;
    if (total >= price) begin
      excess = total - price;
      r.pr   = 1'b1;
      r.re   = (excess != '0);
      r.next = (excess != '0) ? excess - calc_t'(1) : '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/vm_if.sv
// Coin-in / dispense-out bundle between the coin acceptor, the vending
// controller and the product/change dispenser drivers.
interface vm_if;

  logic rs1;
  logic rs2;
  logic pr;
  logic re;

  modport master (output rs1, output rs2, input pr, input re);
  modport slave  (input rs1, input rs2, output pr, output re);

endinterface

// File: rtl/vending_machine_ml.sv
// Mealy coin vending controller with a single credit register.
// Define VM_REG_OUT_EN to register pr/re (one cycle later, credit timing unchanged).
module vending_machine_ml
  import vm_pkg::*;
#(
  parameter int PRICE = 3,
  parameter int CW    = 3
) (
  input  logic clk,
  input  logic rst,
  vm_if.slave  bus
);

  logic [CW-1:0] credit_q;
  logic [CW-1:0] credit_d;
  logic [CW-1:0] coin;
  logic [CW-1:0] total;
  vend_t         vend;
  logic          pr_d;
  logic          re_d;

  // Both coins in one sample add up to three units
  always_comb begin
    coin = '0;
    if (bus.rs1) coin = coin + CW'(COIN1);
    if (bus.rs2) coin = coin + CW'(COIN2);
    total    = credit_q + coin;
    vend     = vend_calc(calc_t'(total), calc_t'(PRICE));
    pr_d     = 1'b0;
    re_d     = 1'b0;
    credit_d = credit_q;
    if (rst) begin
      credit_d = '0;
    end else begin
      pr_d     = vend.pr;
      re_d     = vend.re;
      credit_d = CW'(vend.next);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_q <= CW'(S0);
    end else begin
      credit_q <= credit_d;
    end
  end

`ifdef VM_REG_OUT_EN
  logic pr_q;
  logic re_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pr_q <= 1'b0;
      re_q <= 1'b0;
    end else begin
      pr_q <= pr_d;
      re_q <= re_d;
    end
  end

  assign bus.pr = pr_q;
  assign bus.re = re_q;
`else
  assign bus.pr = pr_d;
  assign bus.re = re_d;
`endif

endmodule

// File: tb/tb_vending_machine_ml.sv
// Self-checking bench for vending_machine_ml: PRICE=3 transition table,
// hand-written corner sequences, and randomized coins against a credit model.
module tb_vending_machine_ml;

  localparam int PRICE = 3;

  typedef struct {
    int fromState;
    bit rs1;
    bit rs2;
    bit pr;
    bit re;
    int nextState;
  } vec_t;

  logic clk;
  logic rst;
  vm_if bus ();

  int   checks;
  int   errors;
  int   modelCredit;
  bit   havePrev;
  logic prevPr;
  logic prevRe;
  string prevName;
  vec_t tbl [12];

  vending_machine_ml #(.PRICE(PRICE), .CW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Units paid minus units consumed by vends, with at most one unit refunded per vend
  function automatic void modelStep(input int credit, input bit r, input bit c1, input bit c2,
                                    output bit ePr, output bit eRe, output int eNext);
    int paid;
    paid  = credit + (c1 ? 1 : 0) + (c2 ? 2 : 0);
    ePr   = 1'b0;
    eRe   = 1'b0;
    eNext = paid;
    if (r) begin
      eNext = 0;
    end else if (paid >= PRICE) begin
      ePr   = 1'b1;
      eRe   = (paid - PRICE) > 0;
      eNext = (paid - PRICE) > 0 ? paid - PRICE - 1 : 0;
    end
  endfunction

  task automatic applyStimulus(input bit r, input bit c1, input bit c2, input bit ePr, input bit eRe,
                               input int eCredit, input string name);
    rst     = r;
    bus.rs1 = c1;
    bus.rs2 = c2;
    @(negedge clk);
`ifdef VM_REG_OUT_EN
    if (havePrev) begin
      checkOutput({prevName, " pr"}, 32'(bus.pr), 32'(prevPr));
      checkOutput({prevName, " re"}, 32'(bus.re), 32'(prevRe));
    end
    prevPr   = ePr;
    prevRe   = eRe;
    prevName = name;
    havePrev = 1'b1;
`else
    checkOutput({name, " pr"}, 32'(bus.pr), 32'(ePr));
    checkOutput({name, " re"}, 32'(bus.re), 32'(eRe));
`endif
    @(posedge clk);
    #1;
    checkOutput({name, " credit"}, 32'(dut.credit_q), 32'(eCredit));
    modelCredit = eCredit;
  endtask

  initial begin
    bit ePr;
    bit eRe;
    int eNext;
    bit r;
    bit c1;
    bit c2;

    checks   = 0;
    errors   = 0;
    havePrev = 1'b0;
    prevPr   = 1'b0;
    prevRe   = 1'b0;
    prevName = "";
    rst      = 1'b1;
    bus.rs1  = 1'b0;
    bus.rs2  = 1'b0;

    tbl[0]  = '{0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 0, 0, 0, 1};
    tbl[2]  = '{0, 0, 1, 0, 0, 2};
    tbl[3]  = '{0, 1, 1, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0, 1};
    tbl[5]  = '{1, 1, 0, 0, 0, 2};
    tbl[6]  = '{1, 0, 1, 1, 0, 0};
    tbl[7]  = '{1, 1, 1, 1, 1, 0};
    tbl[8]  = '{2, 0, 0, 0, 0, 2};
    tbl[9]  = '{2, 1, 0, 1, 0, 0};
    tbl[10] = '{2, 0, 1, 1, 1, 0};
    tbl[11] = '{2, 1, 1, 1, 1, 1};

    // Reset, then idle
    applyStimulus(1, 0, 0, 0, 0, 0, "t1 reset");
    applyStimulus(0, 0, 0, 0, 0, 0, "t1 idle a");
    applyStimulus(0, 0, 0, 0, 0, 0, "t1 idle b");

    // Two 2-unit coins: S2, then vend with change
    applyStimulus(0, 0, 0, 0, 0, 0, "t2 idle");
    applyStimulus(0, 0, 1, 0, 0, 2, "t2 coin2 a");
    applyStimulus(0, 0, 1, 1, 1, 0, "t2 coin2 b");

    applyStimulus(0, 1, 0, 0, 0, 1, "t3 coin1");
    applyStimulus(0, 1, 1, 1, 1, 0, "t3 both");
    applyStimulus(0, 1, 0, 0, 0, 1, "t3 coin1 b");
    applyStimulus(0, 0, 1, 1, 0, 0, "t3 coin2");

    // Total of five keeps one unit as credit
    applyStimulus(0, 0, 1, 0, 0, 2, "t4 coin2");
    applyStimulus(0, 1, 1, 1, 1, 1, "t4 both");
    applyStimulus(0, 0, 1, 1, 0, 0, "t4 coin2 b");

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 0, $sformatf("t5 held %0d", i));
    end

    // Reset mid-accumulation drops the credit and the coin
    applyStimulus(0, 0, 1, 0, 0, 2, "t6 coin2");
    applyStimulus(1, 1, 0, 0, 0, 0, "t6 rst coin1");
    applyStimulus(0, 1, 0, 0, 0, 1, "t6 coin1");

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0, "tbl reset");
      if (tbl[i].fromState == 1) applyStimulus(0, 1, 0, 0, 0, 1, "tbl pre S1");
      if (tbl[i].fromState == 2) applyStimulus(0, 0, 1, 0, 0, 2, "tbl pre S2");
      applyStimulus(0, tbl[i].rs1, tbl[i].rs2, tbl[i].pr, tbl[i].re, tbl[i].nextState,
                    $sformatf("tbl S%0d %0b%0b", tbl[i].fromState, tbl[i].rs1, tbl[i].rs2));
    end

    for (int i = 0; i < 300; i++) begin
      r  = ($urandom_range(0, 15) == 0);
      c1 = $urandom_range(0, 1) == 1;
      c2 = $urandom_range(0, 1) == 1;
      modelStep(modelCredit, r, c1, c2, ePr, eRe, eNext);
      applyStimulus(r, c1, c2, ePr, eRe, eNext, $sformatf("rand %0d", i));
    end
    applyStimulus(0, 0, 0, 0, 0, modelCredit, "final idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
